// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Resolves the conditional branch or jump sitting in EX and sequences the
// pipeline redirect. When the actual outcome disagrees with the fetch-time
// prediction, it asserts a one-cycle PC redirect together with flushes of
// IF/ID, ID/EX and EX/MEM. The redirect is held while the pipeline stalls.
// Two saturating counters track resolved control-flow instructions and
// mispredicts for performance monitoring.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   reset          - synchronous, active-high
//   ex_valid       - EX holds a live instruction
//   ex_is_branch   - EX instruction is a conditional branch
//   ex_is_jump     - EX instruction is jal/jalr (always taken)
//   branch_src     - comparison: 000 beq, 001 bne, 010 blt, 011 bge,
//                    100 bltu, 101 bgeu, others never taken
//   rs1_val        - forwarded operand 1
//   rs2_val        - forwarded operand 2
//   ex_pc          - PC of the EX instruction
//   target_pc      - computed branch/jump target
//   ex_pred_taken  - prediction made at fetch time
//   stall          - pipeline hold, EX contents frozen
//   redirect_valid - load redirect_pc into the PC this cycle
//   redirect_pc    - corrected fetch address
//   flush_if_id    - squash IF/ID
//   flush_id_ex    - squash ID/EX
//   flush_ex_mem   - squash the wrong-path instruction entering MEM
//   resolved_valid - one-cycle pulse per resolved control-flow instruction
//   resolved_taken - actual outcome, meaningful with resolved_valid
//   branch_cnt     - saturating count of resolved control-flow instructions
//   mispred_cnt    - saturating count of mispredicts
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic [2:0]       branch_src,
   input  logic [XLEN-1:0]  rs1_val,
   input  logic [XLEN-1:0]  rs2_val,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  target_pc,
   input  logic             ex_pred_taken,
   input  logic             stall,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             resolved_valid,
   output logic             resolved_taken,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   typedef enum logic {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic cond;
   logic taken;
   logic resolve;
   logic mispredict;

   // Branch comparison on the forwarded operands. Equality works on raw
   // bits, blt/bge treat the operands as two's complement, bltu/bgeu as
   // unsigned. The two unused encodings are simply never taken.
   always_comb begin
      cond = 1'b0;
      case (branch_src)
         3'b000:  cond = (rs1_val == rs2_val);
         3'b001:  cond = (rs1_val != rs2_val);
         3'b010:  cond = ($signed(rs1_val) <  $signed(rs2_val));
         3'b011:  cond = ($signed(rs1_val) >= $signed(rs2_val));
         3'b100:  cond = (rs1_val <  rs2_val);
         3'b101:  cond = (rs1_val >= rs2_val);
         default: cond = 1'b0;
      endcase
   end

   // A jump wins over the branch flag when both are set, since a jump is
   // unconditionally taken regardless of the comparison result.
   assign taken = ex_is_jump | (ex_is_branch & cond);

   // Next-state and output decode. Only IDLE may resolve: while REDIRECT is
   // active the EX stage holds a wrong-path instruction, so its contents are
   // ignored. A stall in REDIRECT simply keeps the redirect and flushes up
   // until the pipeline is able to accept them.
   always_comb begin
      state_next     = state;
      redirect_valid = 1'b0;
      flush_if_id    = 1'b0;
      flush_id_ex    = 1'b0;
      flush_ex_mem   = 1'b0;
      resolve        = 1'b0;
      mispredict     = 1'b0;
      case (state)
         IDLE: begin
            resolve    = ex_valid & (ex_is_branch | ex_is_jump) & ~stall;
            mispredict = resolve & (taken != ex_pred_taken);
            if (mispredict) begin
               state_next = REDIRECT;
            end
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            flush_ex_mem   = 1'b1;
            if (!stall) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   // State register. Reset drops straight back to IDLE, which also cancels
   // any redirect that was in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Resolution pulse, redirect address and performance counters. The
   // redirect address is captured at resolve time and held afterwards so it
   // stays stable for as long as REDIRECT is stalled. Counters stop at
   // all-ones rather than wrapping so long runs never read as small values.
   always_ff @(posedge clk) begin
      if (reset) begin
         resolved_valid <= 1'b0;
         resolved_taken <= 1'b0;
         redirect_pc    <= '0;
         branch_cnt     <= '0;
         mispred_cnt    <= '0;
      end else begin
         resolved_valid <= resolve;
         resolved_taken <= resolve & taken;
         if (mispredict) begin
            redirect_pc <= taken ? target_pc : (ex_pc + XLEN'(4));
         end
         if (resolve && (branch_cnt != {CNT_W{1'b1}})) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (mispredict && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//
// Self-checking bench for branch_redirect_ctrl. Two instances share every
// input: one with the default 16-bit counters and one with 4-bit counters so
// saturation is reachable quickly. A behavioural model tracks whether a
// redirect is outstanding, the redirect address and unbounded event counts;
// expected counter values are the unbounded counts clipped to each width.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [2:0]  branch_src;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] ex_pc;
   logic [31:0] target_pc;
   logic        ex_pred_taken;
   logic        stall;

   logic        redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem;
   logic [31:0] redirect_pc;
   logic        resolved_valid, resolved_taken;
   logic [15:0] branch_cnt, mispred_cnt;

   logic        s_redirect_valid, s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
   logic [31:0] s_redirect_pc;
   logic        s_resolved_valid, s_resolved_taken;
   logic [3:0]  s_branch_cnt, s_mispred_cnt;

   logic [3:0]  ctrl;
   assign ctrl = {redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem};

   int passed = 0;
   int total  = 0;

   // Reference model state.
   bit          m_redirect;
   logic [31:0] m_rpc;
   bit          m_rv;
   bit          m_rt;
   int          m_br;
   int          m_mp;

   branch_redirect_ctrl #(.XLEN(32), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .branch_src(branch_src), .rs1_val(rs1_val),
      .rs2_val(rs2_val), .ex_pc(ex_pc), .target_pc(target_pc),
      .ex_pred_taken(ex_pred_taken), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
      .resolved_valid(resolved_valid), .resolved_taken(resolved_taken),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   branch_redirect_ctrl #(.XLEN(32), .CNT_W(4)) u_small (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .branch_src(branch_src), .rs1_val(rs1_val),
      .rs2_val(rs2_val), .ex_pc(ex_pc), .target_pc(target_pc),
      .ex_pred_taken(ex_pred_taken), .stall(stall),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
      .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .flush_ex_mem(s_flush_ex_mem),
      .resolved_valid(s_resolved_valid), .resolved_taken(s_resolved_taken),
      .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] sat16(int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   function automatic logic [3:0] sat4(int v);
      return (v > 15) ? 4'hF : 4'(v);
   endfunction

   // Quiet all EX inputs, leaving reset alone.
   task automatic set_idle();
      ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; branch_src = 3'd0;
      rs1_val = 0; rs2_val = 0; ex_pc = 0; target_pc = 0;
      ex_pred_taken = 0; stall = 0;
   endtask

   task automatic drive(input bit v, input bit br, input bit jmp, input logic [2:0] src,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit pred, input bit stl);
      ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; branch_src = src;
      rs1_val = a; rs2_val = b; ex_pc = pc; target_pc = tgt;
      ex_pred_taken = pred; stall = stl;
   endtask

   // Advance the model by the rules of the block using the inputs currently
   // applied, then step the clock and settle past the edge.
   task automatic tick();
      bit cond, taken, resolve;
      if (reset) begin
         m_redirect = 0; m_rpc = 0; m_rv = 0; m_rt = 0; m_br = 0; m_mp = 0;
      end else begin
         case (branch_src)
            3'd0:    cond = (rs1_val == rs2_val);
            3'd1:    cond = (rs1_val != rs2_val);
            3'd2:    cond = ($signed(rs1_val) < $signed(rs2_val));
            3'd3:    cond = !($signed(rs1_val) < $signed(rs2_val));
            3'd4:    cond = (rs1_val < rs2_val);
            3'd5:    cond = !(rs1_val < rs2_val);
            default: cond = 0;
         endcase
         taken   = ex_is_jump || (ex_is_branch && cond);
         resolve = ex_valid && (ex_is_branch || ex_is_jump) && !stall && !m_redirect;
         m_rv = resolve;
         m_rt = resolve && taken;
         if (resolve) m_br++;
         if (m_redirect) begin
            if (!stall) m_redirect = 0;
         end else if (resolve && (taken != ex_pred_taken)) begin
            m_mp++;
            m_redirect = 1;
            m_rpc = taken ? target_pc : ex_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; set_idle();
      tick(); tick();
      reset = 0;
      total++; if (ctrl !== 4'h0) $display("[TB] FAIL reset_ctrl: got %h expected %h", ctrl, 4'h0); else passed++;
      total++; if (redirect_pc !== 32'h0) $display("[TB] FAIL reset_rpc: got %h expected %h", redirect_pc, 32'h0); else passed++;
      total++; if ({resolved_valid, resolved_taken} !== 2'b00) $display("[TB] FAIL reset_resolved: got %b expected 00", {resolved_valid, resolved_taken}); else passed++;
      total++; if ({branch_cnt, mispred_cnt} !== 32'h0) $display("[TB] FAIL reset_cnt: got %h expected %h", {branch_cnt, mispred_cnt}, 32'h0); else passed++;
      total++; if ({s_branch_cnt, s_mispred_cnt} !== 8'h0) $display("[TB] FAIL reset_small_cnt: got %h expected %h", {s_branch_cnt, s_mispred_cnt}, 8'h0); else passed++;
   endtask

   task automatic test_beq_mispredict();
      drive(1, 1, 0, 3'd0, 32'd5, 32'd5, 32'h80, 32'h100, 0, 0);
      tick();
      total++; if (ctrl !== 4'hF) $display("[TB] FAIL beq_ctrl: got %h expected %h", ctrl, 4'hF); else passed++;
      total++; if (redirect_pc !== 32'h100) $display("[TB] FAIL beq_rpc: got %h expected %h", redirect_pc, 32'h100); else passed++;
      total++; if ({resolved_valid, resolved_taken} !== 2'b11) $display("[TB] FAIL beq_resolved: got %b expected 11", {resolved_valid, resolved_taken}); else passed++;
      total++; if (mispred_cnt !== 16'd1) $display("[TB] FAIL beq_mispred_cnt: got %0d expected 1", mispred_cnt); else passed++;
      set_idle();
      tick();
      total++; if (ctrl !== 4'h0) $display("[TB] FAIL beq_one_cycle: got %h expected %h", ctrl, 4'h0); else passed++;
      total++; if (resolved_valid !== 1'b0) $display("[TB] FAIL beq_pulse: got %b expected 0", resolved_valid); else passed++;
   endtask

   task automatic test_signed_unsigned();
      drive(1, 1, 0, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h300, 1, 0);
      tick();
      total++; if (ctrl !== 4'h0) $display("[TB] FAIL blt_ctrl: got %h expected %h", ctrl, 4'h0); else passed++;
      total++; if ({resolved_valid, resolved_taken} !== 2'b11) $display("[TB] FAIL blt_resolved: got %b expected 11", {resolved_valid, resolved_taken}); else passed++;
      total++; if ({branch_cnt, mispred_cnt} !== {16'd2, 16'd1}) $display("[TB] FAIL blt_cnt: got %h expected %h", {branch_cnt, mispred_cnt}, {16'd2, 16'd1}); else passed++;
      // Not-taken fall-through from the top of the address space wraps to 0.
      drive(1, 1, 0, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h300, 1, 0);
      tick();
      total++; if (ctrl !== 4'hF) $display("[TB] FAIL bltu_ctrl: got %h expected %h", ctrl, 4'hF); else passed++;
      total++; if (redirect_pc !== 32'h0) $display("[TB] FAIL bltu_rpc_wrap: got %h expected %h", redirect_pc, 32'h0); else passed++;
      total++; if ({resolved_valid, resolved_taken} !== 2'b10) $display("[TB] FAIL bltu_resolved: got %b expected 10", {resolved_valid, resolved_taken}); else passed++;
      set_idle();
      tick();
   endtask

   task automatic test_stall_in_redirect();
      // bge with 3 >= 7 false, predicted taken: redirect to pc+4.
      drive(1, 1, 0, 3'd3, 32'd3, 32'd7, 32'h400, 32'h900, 1, 0);
      tick();
      total++; if (redirect_pc !== 32'h404) $display("[TB] FAIL bge_rpc: got %h expected %h", redirect_pc, 32'h404); else passed++;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 3'd0, 32'd1, 32'd2, 32'h700, 32'h800, 0, 1);
         tick();
         total++; if (ctrl !== 4'hF) $display("[TB] FAIL stall_hold_ctrl: got %h expected %h", ctrl, 4'hF); else passed++;
         total++; if (redirect_pc !== 32'h404) $display("[TB] FAIL stall_hold_rpc: got %h expected %h", redirect_pc, 32'h404); else passed++;
      end
      drive(1, 0, 1, 3'd0, 32'd1, 32'd2, 32'h700, 32'h800, 0, 0);
      tick();
      total++; if (ctrl !== 4'h0) $display("[TB] FAIL stall_release_ctrl: got %h expected %h", ctrl, 4'h0); else passed++;
      total++; if ({branch_cnt, mispred_cnt} !== {16'd4, 16'd3}) $display("[TB] FAIL stall_redirect_cnt: got %h expected %h", {branch_cnt, mispred_cnt}, {16'd4, 16'd3}); else passed++;
      set_idle();
      tick();
   endtask

   task automatic test_stall_in_idle();
      int pulses;
      reset = 1; set_idle(); tick(); reset = 0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 3'd0, 32'd1, 32'd2, 32'h40, 32'h80, 0, 1);
         tick();
         if (resolved_valid) pulses++;
      end
      drive(1, 1, 0, 3'd0, 32'd1, 32'd2, 32'h40, 32'h80, 0, 0);
      tick();
      if (resolved_valid) pulses++;
      set_idle();
      tick();
      if (resolved_valid) pulses++;
      total++; if (pulses != 1) $display("[TB] FAIL stall_idle_pulses: got %0d expected 1", pulses); else passed++;
      total++; if (branch_cnt !== 16'd1) $display("[TB] FAIL stall_idle_branch_cnt: got %0d expected 1", branch_cnt); else passed++;
   endtask

   task automatic test_back_to_back();
      reset = 1; set_idle(); tick(); reset = 0;
      drive(1, 0, 1, 3'd0, 32'd0, 32'd0, 32'h500, 32'hA00, 0, 0);
      tick();
      total++; if (ctrl !== 4'hF) $display("[TB] FAIL b2b_first_ctrl: got %h expected %h", ctrl, 4'hF); else passed++;
      drive(1, 1, 0, 3'd0, 32'd9, 32'd9, 32'h504, 32'hB00, 0, 0);
      tick();
      total++; if ({ctrl, resolved_valid} !== 5'b0) $display("[TB] FAIL b2b_ignored: got %b expected 00000", {ctrl, resolved_valid}); else passed++;
      total++; if ({branch_cnt, mispred_cnt} !== {16'd1, 16'd1}) $display("[TB] FAIL b2b_cnt: got %h expected %h", {branch_cnt, mispred_cnt}, {16'd1, 16'd1}); else passed++;
      set_idle();
      tick();
   endtask

   task automatic test_jump_priority_and_unused_src();
      drive(1, 1, 1, 3'd6, 32'd1, 32'd2, 32'h600, 32'hC00, 0, 0);
      tick();
      total++; if (redirect_pc !== 32'hC00) $display("[TB] FAIL both_flags_rpc: got %h expected %h", redirect_pc, 32'hC00); else passed++;
      set_idle(); tick();
      drive(1, 1, 0, 3'd7, 32'd4, 32'd4, 32'h610, 32'hD00, 1, 0);
      tick();
      total++; if ({resolved_valid, resolved_taken} !== 2'b10) $display("[TB] FAIL src7_resolved: got %b expected 10", {resolved_valid, resolved_taken}); else passed++;
      total++; if (redirect_pc !== 32'h614) $display("[TB] FAIL src7_rpc: got %h expected %h", redirect_pc, 32'h614); else passed++;
      set_idle(); tick();
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      int errs;
      errs = 0;
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h5;
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
               3'($urandom_range(0, 7)), pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
               {$urandom, 2'b00} & 32'hFFFF_FFFC, {$urandom, 2'b00} & 32'hFFFF_FFFC,
               $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
         tick();
         total++;
         if (ctrl !== {4{m_redirect}} || redirect_pc !== m_rpc || resolved_valid !== m_rv ||
             (m_rv && resolved_taken !== m_rt) || branch_cnt !== sat16(m_br) || mispred_cnt !== sat16(m_mp)) begin
            errs++;
            if (errs <= 5)
               $display("[TB] FAIL rand_main cyc %0d: got ctrl=%h rpc=%h rv=%b rt=%b br=%0d mp=%0d expected ctrl=%h rpc=%h rv=%b rt=%b br=%0d mp=%0d",
                        i, ctrl, redirect_pc, resolved_valid, resolved_taken, branch_cnt, mispred_cnt,
                        {4{m_redirect}}, m_rpc, m_rv, m_rt, sat16(m_br), sat16(m_mp));
         end else passed++;
         total++;
         if (s_branch_cnt !== sat4(m_br) || s_mispred_cnt !== sat4(m_mp) || s_redirect_valid !== m_redirect) begin
            errs++;
            if (errs <= 5)
               $display("[TB] FAIL rand_small cyc %0d: got br=%0d mp=%0d rv=%b expected br=%0d mp=%0d rv=%b",
                        i, s_branch_cnt, s_mispred_cnt, s_redirect_valid, sat4(m_br), sat4(m_mp), m_redirect);
         end else passed++;
      end
      reset = 0;
      set_idle();
      tick();
   endtask

   task automatic test_saturation();
      reset = 1; set_idle(); tick(); reset = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 1, 3'd0, 32'd0, 32'd0, 32'h1000 + 32'(i * 8), 32'h2000, 0, 0);
         tick();
         set_idle();
         tick();
      end
      total++; if ({s_branch_cnt, s_mispred_cnt} !== 8'hFF) $display("[TB] FAIL sat_small: got %h expected %h", {s_branch_cnt, s_mispred_cnt}, 8'hFF); else passed++;
      total++; if ({branch_cnt, mispred_cnt} !== {16'd20, 16'd20}) $display("[TB] FAIL sat_main: got %h expected %h", {branch_cnt, mispred_cnt}, {16'd20, 16'd20}); else passed++;
   endtask

   task automatic test_reset_mid_redirect();
      drive(1, 0, 1, 3'd0, 32'd0, 32'd0, 32'h3000, 32'h4000, 0, 0);
      tick();
      total++; if (ctrl !== 4'hF) $display("[TB] FAIL rst_mid_pre: got %h expected %h", ctrl, 4'hF); else passed++;
      reset = 1; stall = 1;
      tick();
      reset = 0;
      total++; if ({ctrl, resolved_valid, redirect_pc} !== 37'h0) $display("[TB] FAIL rst_mid_outputs: got %h expected %h", {ctrl, resolved_valid, redirect_pc}, 37'h0); else passed++;
      total++; if ({branch_cnt, mispred_cnt, s_branch_cnt, s_mispred_cnt} !== 40'h0) $display("[TB] FAIL rst_mid_cnt: got %h expected %h", {branch_cnt, mispred_cnt, s_branch_cnt, s_mispred_cnt}, 40'h0); else passed++;
      set_idle();
      tick();
      total++; if (ctrl !== 4'h0) $display("[TB] FAIL rst_mid_after: got %h expected %h", ctrl, 4'h0); else passed++;
   endtask

   initial begin
      reset = 1;
      set_idle();
      test_reset();
      test_beq_mispredict();
      test_signed_unsigned();
      test_stall_in_redirect();
      test_stall_in_idle();
      test_back_to_back();
      test_jump_priority_and_unused_src();
      test_random();
      test_saturation();
      test_reset_mid_redirect();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
